vc_writeback_unit: RTL
======================

VC_WRITEBACK_UNIT -- requirements
Module: vc_writeback_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 wb_req  input  1  victim-cache eviction request, level-sensitive.
REQ-005 wb_way  input  2  victim way to write back: 00=A, 01=B, 10=C, 11=D.
REQ-006 wb_addr  input  16  lc3b_word byte address of the evicted line.
REQ-007 data_in_A / data_in_B / data_in_C / data_in_D  input  128 each  lc3b_burst outputs of the victim data array.
REQ-008 wb_ready  output  1  high when a request can be accepted this cycle.
REQ-009 wb_done  output  1  one-cycle pulse when a writeback completes.
REQ-010 pmem_write  output  1  physical memory write strobe.
REQ-011 pmem_address  output  16  physical memory line address.
REQ-012 pmem_wdata  output  128  physical memory write burst.
REQ-013 pmem_resp  input  1  physical memory completion, single-cycle pulse.
REQ-014 wb_count  output  16  count of completed writebacks.

Function
REQ-015 The FSM SHALL have three states: IDLE, WRITE and DONE.
REQ-016 wb_ready SHALL be 1 only in IDLE, derived combinationally from state.
REQ-017 Acceptance SHALL occur at a rising edge where state=IDLE and wb_req=1.
REQ-018 On acceptance the block SHALL capture, in the same edge, the following, then enter WRITE:
- the burst selected by wb_way from data_in_A..D into a 128-bit line buffer;
- wb_addr with bits [3:0] forced to 0 into an address register.
REQ-019 After capture, the line buffer SHALL be independent of data_in_A..D; later array loads to any way, including the captured way, SHALL NOT alter the data written.
REQ-020 In WRITE the block SHALL drive the following, held stable until pmem_resp:
- pmem_write=1;
- pmem_address = the address register;
- pmem_wdata = the line buffer.
REQ-021 In WRITE with pmem_resp=1 at a rising edge, the block SHALL enter DONE; pmem_write SHALL be 0 from the following cycle.
REQ-022 pmem_resp SHALL be ignored in IDLE and DONE.
REQ-023 In DONE the block SHALL:
- assert wb_done=1 for exactly one cycle;
- increment wb_count by 1, saturating at 16'hFFFF with no wrap;
- return to IDLE.
REQ-024 wb_req asserted in WRITE or DONE SHALL NOT be accepted; the requester SHALL hold wb_req until it samples wb_ready=1.
REQ-025 Minimum request-to-request spacing SHALL be 3 cycles: accept, at least one WRITE cycle, DONE.
REQ-026 Outside WRITE, pmem_write SHALL be 0 and pmem_address and pmem_wdata SHALL hold their last registered values.
REQ-027 Latency from acceptance to the first pmem_write=1 cycle SHALL be 1 cycle.
REQ-028 Latency from the pmem_resp edge to wb_done=1 SHALL be 1 cycle.
REQ-029 wb_way is 2 bits and all four codes are valid; the block SHALL have no illegal-way condition.

Reset
REQ-030 reset_n=0 SHALL immediately, without waiting for clk, force the following:
- state=IDLE, wb_ready=1;
- pmem_write=0, wb_done=0;
- pmem_address=16'h0000, pmem_wdata=128'b0, wb_count=16'h0000.
REQ-031 Reset asserted mid-WRITE SHALL abort the transfer, deassert pmem_write in the same cycle, and SHALL NOT increment wb_count.
REQ-032 After reset_n rises, the first acceptance SHALL be possible at the next rising edge.

Verification
REQ-033 Basic writeback scenario:
- stimulus: data_in_C=128'hCAFE...01, wb_way=10, wb_addr=16'h1237, wb_req=1 in IDLE; pmem_resp pulsed 4 cycles after acceptance;
- response: pmem_write=1 for exactly 4 cycles, pmem_address=16'h1230, pmem_wdata=128'hCAFE...01, wb_done pulses once, wb_count=1.
REQ-034 Array overwrite after capture:
- stimulus: capture way A, then change data_in_A on the next cycle;
- response: pmem_wdata still equals the originally captured value.
REQ-035 Back-to-back requests:
- stimulus: wb_req held high with way B then way D, pmem_resp after 1 cycle each;
- response: acceptances 3 cycles apart, wb_ready low in between, two wb_done pulses, wb_count=2.
REQ-036 Reset mid-transfer:
- stimulus: reset_n=0 asynchronously during WRITE;
- response: pmem_write=0 before the next edge, state=IDLE, wb_count unchanged at 0.
REQ-037 Counter saturation:
- stimulus: preload wb_count to 16'hFFFE via repeated writebacks, then complete 2 more;
- response: wb_count=16'hFFFF, no wrap.
REQ-038 Stray memory response:
- stimulus: pmem_resp=1 while in IDLE;
- response: no state change, wb_done stays 0.

Source files
------------

// File: rtl/vc_writeback_unit.sv
// Victim-cache writeback engine: latches one evicted line and its line address,
// drives it to physical memory until acknowledged, then pulses done and counts it.
module vc_writeback_unit #(
   parameter logic [15:0] COUNT_SAT = 16'hFFFF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wb_req,
   input  logic [1:0]   wb_way,
   input  logic [15:0]  wb_addr,
   input  logic [127:0] data_in_A,
   input  logic [127:0] data_in_B,
   input  logic [127:0] data_in_C,
   input  logic [127:0] data_in_D,
   output logic         wb_ready,
   output logic         wb_done,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic         pmem_resp,
   output logic [15:0]  wb_count
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

   state_e        state_q, state_d;
   logic          pmem_write_q, pmem_write_d;
   logic          wb_done_q, wb_done_d;
   logic [15:0]   addr_q, addr_d;
   logic [127:0]  line_q, line_d;
   logic [15:0]   wb_count_q, wb_count_d;

   // The line buffer is loaded only on acceptance, so later array writes to the
   // captured way cannot disturb a transfer already in flight.
   always_comb begin
      state_d      = state_q;
      pmem_write_d = pmem_write_q;
      wb_done_d    = 1'b0;
      addr_d       = addr_q;
      line_d       = line_q;
      wb_count_d   = wb_count_q;
      case (state_q)
         IDLE: begin
            if (wb_req) begin
               case (wb_way)
                  2'b00:   line_d = data_in_A;
                  2'b01:   line_d = data_in_B;
                  2'b10:   line_d = data_in_C;
                  default: line_d = data_in_D;
               endcase
               addr_d       = {wb_addr[15:4], 4'h0};
               pmem_write_d = 1'b1;
               state_d      = WRITE;
            end
         end
         WRITE: begin
            if (pmem_resp) begin
               pmem_write_d = 1'b0;
               wb_done_d    = 1'b1;
               state_d      = DONE;
               // Counter sticks at its ceiling rather than wrapping to zero.
               if (wb_count_q != COUNT_SAT) begin
                  wb_count_d = wb_count_q + 16'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d      = IDLE;
            pmem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         pmem_write_q <= 1'b0;
         wb_done_q    <= 1'b0;
         addr_q       <= 16'h0000;
         line_q       <= '0;
         wb_count_q   <= 16'h0000;
      end else begin
         state_q      <= state_d;
         pmem_write_q <= pmem_write_d;
         wb_done_q    <= wb_done_d;
         addr_q       <= addr_d;
         line_q       <= line_d;
         wb_count_q   <= wb_count_d;
      end
   end

   assign wb_ready     = (state_q == IDLE);
   assign wb_done      = wb_done_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = line_q;
   assign wb_count     = wb_count_q;

endmodule
